// File: rtl/re_order_buffer_mr_if.sv
// Dispatch / write-back / retire / recovery bundle of the multi-port reorder buffer.
// The pipeline front end drives the master side; the ROB implements the slave side.
interface re_order_buffer_mr_if #(
  parameter int ROB_LEN = 16,
  parameter int DISP    = 3,
  parameter int RET     = 2,
  parameter int WB      = 4,
  parameter int DAT_W   = 32,
  parameter int RES_W   = 32
);
  localparam int PW = $clog2(ROB_LEN);

  logic [DISP-1:0]             dsp_p;
  logic [DISP-1:0][DAT_W-1:0]  dsp_dat;
  logic [DISP-1:0][PW-1:0]     dsp_ptr;
  logic [PW:0]                 dsp_num_avail;
  logic [PW:0]                 occ;

  logic [WB-1:0]               wb_v;
  logic [WB-1:0][PW-1:0]       wb_ptr;
  logic [WB-1:0][RES_W-1:0]    wb_res;
  logic [WB-1:0]               wb_exc;

  logic [RET-1:0]              ret_v;
  logic [RET-1:0][DAT_W-1:0]   ret_dat;
  logic [RET-1:0][RES_W-1:0]   ret_res;
  logic [RET-1:0]              ret_exc;
  logic [RET-1:0][PW-1:0]      ret_ptr;
  logic [RET-1:0]              ret_p;

  logic                        flush;
  logic                        squash;
  logic [PW-1:0]               squash_ptr;

  modport master (
    output dsp_p, dsp_dat, wb_v, wb_ptr, wb_res, wb_exc, ret_p, flush, squash, squash_ptr,
    input  dsp_ptr, dsp_num_avail, occ, ret_v, ret_dat, ret_res, ret_exc, ret_ptr
  );

  modport slave (
    input  dsp_p, dsp_dat, wb_v, wb_ptr, wb_res, wb_exc, ret_p, flush, squash, squash_ptr,
    output dsp_ptr, dsp_num_avail, occ, ret_v, ret_dat, ret_res, ret_exc, ret_ptr
  );
endinterface

// File: rtl/re_order_buffer_mr.sv
// Multi-port reorder buffer: in-order dispatch and retire, out-of-order write-back,
// results and exception flags stored per slot, full flush and partial squash.
module re_order_buffer_mr #(
  parameter int ROB_LEN = 16,
  parameter int DISP    = 3,
  parameter int RET     = 2,
  parameter int WB      = 4,
  parameter int DAT_W   = 32,
  parameter int RES_W   = 32
) (
  input logic clk,
  input logic rst,
  re_order_buffer_mr_if.slave bus
);
  localparam int PW = $clog2(ROB_LEN);

  if ((1 << PW) != ROB_LEN) begin : g_bad_len
    $error("re_order_buffer_mr: ROB_LEN must be a power of 2");
  end

  logic [PW:0]              rptr, wptr, occ_w, avail_w;
  logic [DAT_W-1:0]         dat_q [ROB_LEN];
  logic [RES_W-1:0]         res_q [ROB_LEN];
  logic [ROB_LEN-1:0]       exc_q, done_q;

  logic [PW-1:0]            rslot, sq_off;
  logic                     sq_hit, disp_ok;
  logic                     chain, run_d, run_r;
  logic [PW:0]              n_disp, n_ret, n_keep;
  logic [ROB_LEN-1:0]       keep;
  logic [RET-1:0]           ret_v_w;
  logic [RET-1:0][PW-1:0]   ret_ptr_w;
  logic [DISP-1:0][PW-1:0]  dsp_ptr_w;

  // Wrap bit on both pointers separates full (occ = ROB_LEN) from empty.
  assign rslot   = rptr[PW-1:0];
  assign occ_w   = wptr - rptr;
  assign avail_w = (PW+1)'(ROB_LEN) - occ_w;

  always_comb begin
    for (int i = 0; i < DISP; i++) dsp_ptr_w[i] = wptr[PW-1:0] + PW'(i);
    for (int i = 0; i < RET; i++)  ret_ptr_w[i] = rslot + PW'(i);
  end

  // Retirable chain stops after the first faulting entry.
  always_comb begin
    ret_v_w = '0;
    chain   = 1'b1;
    for (int i = 0; i < RET; i++) begin
      ret_v_w[i] = chain && ((PW+1)'(i) < occ_w) && done_q[ret_ptr_w[i]];
      chain      = ret_v_w[i] && !exc_q[ret_ptr_w[i]];
    end
  end

  // n_keep is the number of entries that survive this cycle's squash.
  always_comb begin
    sq_off = bus.squash_ptr - rslot;
    sq_hit = bus.squash && ({1'b0, sq_off} < occ_w);
    n_keep = sq_hit ? ({1'b0, sq_off} + 1'b1) : occ_w;
    for (int s = 0; s < ROB_LEN; s++) keep[s] = {1'b0, PW'(s) - rslot} < n_keep;
  end

  always_comb begin
    n_disp = '0;
    run_d  = 1'b1;
    for (int i = 0; i < DISP; i++) begin
      run_d = run_d && bus.dsp_p[i];
      if (run_d) n_disp = n_disp + 1'b1;
    end
    disp_ok = !sq_hit && (n_disp <= avail_w);

    n_ret = '0;
    run_r = 1'b1;
    for (int i = 0; i < RET; i++) begin
      run_r = run_r && bus.ret_p[i] && ret_v_w[i] && ((PW+1)'(i) < n_keep);
      if (run_r) n_ret = n_ret + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr   <= '0;
      wptr   <= '0;
      exc_q  <= '0;
      done_q <= '0;
      for (int s = 0; s < ROB_LEN; s++) begin
        dat_q[s] <= '0;
        res_q[s] <= '0;
      end
    end else if (bus.flush) begin
      rptr   <= '0;
      wptr   <= '0;
      done_q <= '0;
    end else begin
      // Ascending port order: the highest port index targeting a slot wins.
      for (int p = 0; p < WB; p++) begin
        if (bus.wb_v[p] && keep[bus.wb_ptr[p]]) begin
          res_q[bus.wb_ptr[p]]  <= bus.wb_res[p];
          exc_q[bus.wb_ptr[p]]  <= bus.wb_exc[p];
          done_q[bus.wb_ptr[p]] <= 1'b1;
        end
      end
      for (int i = 0; i < RET; i++) begin
        if ((PW+1)'(i) < n_ret) done_q[ret_ptr_w[i]] <= 1'b0;
      end
      if (disp_ok) begin
        for (int i = 0; i < DISP; i++) begin
          if ((PW+1)'(i) < n_disp) begin
            dat_q[dsp_ptr_w[i]]  <= bus.dsp_dat[i];
            done_q[dsp_ptr_w[i]] <= 1'b0;
            exc_q[dsp_ptr_w[i]]  <= 1'b0;
          end
        end
      end
      rptr <= rptr + n_ret;
      if (sq_hit)       wptr <= rptr + n_keep;
      else if (disp_ok) wptr <= wptr + n_disp;
    end
  end

  assign bus.occ           = occ_w;
  assign bus.dsp_num_avail = avail_w;
  assign bus.dsp_ptr       = dsp_ptr_w;
  assign bus.ret_ptr       = ret_ptr_w;
  assign bus.ret_v         = ret_v_w;

  always_comb begin
    for (int i = 0; i < RET; i++) begin
      bus.ret_dat[i] = dat_q[ret_ptr_w[i]];
      bus.ret_res[i] = res_q[ret_ptr_w[i]];
      bus.ret_exc[i] = exc_q[ret_ptr_w[i]];
    end
  end
endmodule

// File: tb/tb_re_order_buffer_mr.sv
// Bench for re_order_buffer_mr: directed vector table, recovery sequences, streaming
// wrap test and random traffic checked against a queue-based reference model.
module tb_re_order_buffer_mr;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  re_order_buffer_mr_if bus ();
  re_order_buffer_mr dut (.clk(clk), .rst(rst), .bus(bus));

  int n_err = 0;
  int n_chk = 0;

  // Reference model: the occupied entries as a queue, oldest first.
  typedef struct {
    logic [31:0] dat;
    logic [31:0] res;
    logic        exc;
    logic        done;
  } ent_t;
  ent_t mq[$];
  int   m_rd = 0;

  typedef struct {
    logic [2:0] dsp_p;
    logic       wbv;
    logic [3:0] wbs;
    logic       wbe;
    logic [1:0] ret_p;
    int         occ;
    logic [1:0] rv;
    int         dptr0;
    logic       exc0;
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_ret_v();
    logic [1:0] v = 2'b00;
    for (int i = 0; i < 2; i++)
      if (i < mq.size() && mq[i].done && (i == 0 || (v[i-1] && !mq[i-1].exc))) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rd = 0;
  endtask

  task automatic model_step();
    int sz, keep_n, off, n, k;
    logic sqh;
    logic [1:0] ev;
    if (bus.flush) begin
      model_reset();
      return;
    end
    sz = mq.size();
    keep_n = sz;
    sqh = 1'b0;
    ev = m_ret_v();
    if (bus.squash) begin
      off = (int'(bus.squash_ptr) - m_rd) & 15;
      if (off < sz) begin
        sqh = 1'b1;
        keep_n = off + 1;
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (bus.wb_v[p]) begin
        off = (int'(bus.wb_ptr[p]) - m_rd) & 15;
        if (off < keep_n) begin
          mq[off].res  = bus.wb_res[p];
          mq[off].exc  = bus.wb_exc[p];
          mq[off].done = 1'b1;
        end
      end
    end
    k = 0;
    for (int i = 0; i < 2; i++)
      if (k == i && ev[i] && bus.ret_p[i] && i < keep_n) k++;
    n = 0;
    for (int i = 0; i < 3; i++)
      if (n == i && bus.dsp_p[i]) n++;
    while (mq.size() > keep_n) void'(mq.pop_back());
    repeat (k) void'(mq.pop_front());
    m_rd += k;
    if (!sqh && n <= N - sz)
      for (int i = 0; i < n; i++)
        mq.push_back('{dat: bus.dsp_dat[i], res: 32'h0, exc: 1'b0, done: 1'b0});
  endtask

  task automatic compare_model();
    logic [1:0] ev = m_ret_v();
    chk("occ", 64'(bus.occ), 64'(mq.size()));
    chk("dsp_num_avail", 64'(bus.dsp_num_avail), 64'(N - mq.size()));
    chk("ret_v", 64'(bus.ret_v), 64'(ev));
    for (int i = 0; i < 3; i++)
      chk("dsp_ptr", 64'(bus.dsp_ptr[i]), 64'((m_rd + mq.size() + i) & 15));
    for (int i = 0; i < 2; i++) begin
      chk("ret_ptr", 64'(bus.ret_ptr[i]), 64'((m_rd + i) & 15));
      if (ev[i]) begin
        chk("ret_dat", 64'(bus.ret_dat[i]), 64'(mq[i].dat));
        chk("ret_res", 64'(bus.ret_res[i]), 64'(mq[i].res));
        chk("ret_exc", 64'(bus.ret_exc[i]), 64'(mq[i].exc));
      end
    end
  endtask

  task automatic clear_inputs();
    bus.dsp_p = '0;
    bus.dsp_dat = '0;
    bus.wb_v = '0;
    bus.wb_ptr = '0;
    bus.wb_res = '0;
    bus.wb_exc = '0;
    bus.ret_p = '0;
    bus.flush = 1'b0;
    bus.squash = 1'b0;
    bus.squash_ptr = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic set_wb(input int p, input int slot, input logic exc);
    bus.wb_v[p] = 1'b1;
    bus.wb_ptr[p] = 4'(slot);
    bus.wb_exc[p] = exc;
    bus.wb_res[p] = $urandom;
  endtask

  task automatic set_disp(input logic [2:0] m);
    bus.dsp_p = m;
    for (int i = 0; i < 3; i++) bus.dsp_dat[i] = $urandom;
  endtask

  initial begin
    int next_ret, seq;
    //           dsp_p  wbv  wbs  wbe  ret_p occ rv    dptr0 exc0
    vt[0]  = '{3'b111, 1'b0, 4'd0, 1'b0, 2'b00, 3,  2'b00, 3,  1'b0};
    vt[1]  = '{3'b111, 1'b0, 4'd0, 1'b0, 2'b00, 6,  2'b00, 6,  1'b0};
    vt[2]  = '{3'b111, 1'b0, 4'd0, 1'b0, 2'b00, 9,  2'b00, 9,  1'b0};
    vt[3]  = '{3'b111, 1'b0, 4'd0, 1'b0, 2'b00, 12, 2'b00, 12, 1'b0};
    vt[4]  = '{3'b111, 1'b0, 4'd0, 1'b0, 2'b00, 15, 2'b00, 15, 1'b0};
    vt[5]  = '{3'b111, 1'b0, 4'd0, 1'b0, 2'b00, 15, 2'b00, 15, 1'b0};
    vt[6]  = '{3'b000, 1'b1, 4'd2, 1'b0, 2'b00, 15, 2'b00, 15, 1'b0};
    vt[7]  = '{3'b000, 1'b1, 4'd1, 1'b0, 2'b00, 15, 2'b00, 15, 1'b0};
    vt[8]  = '{3'b000, 1'b1, 4'd0, 1'b0, 2'b00, 15, 2'b11, 15, 1'b0};
    vt[9]  = '{3'b000, 1'b0, 4'd0, 1'b0, 2'b11, 13, 2'b01, 15, 1'b0};
    vt[10] = '{3'b000, 1'b0, 4'd0, 1'b0, 2'b01, 12, 2'b00, 15, 1'b0};
    vt[11] = '{3'b000, 1'b1, 4'd3, 1'b1, 2'b00, 12, 2'b01, 15, 1'b1};
    vt[12] = '{3'b000, 1'b1, 4'd4, 1'b0, 2'b00, 12, 2'b01, 15, 1'b1};
    vt[13] = '{3'b000, 1'b0, 4'd0, 1'b0, 2'b11, 11, 2'b01, 15, 1'b0};
    vt[14] = '{3'b111, 1'b0, 4'd0, 1'b0, 2'b00, 14, 2'b01, 2,  1'b0};
    vt[15] = '{3'b111, 1'b0, 4'd0, 1'b0, 2'b01, 13, 2'b00, 2,  1'b0};

    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_occ", 64'(bus.occ), 64'd0);
    chk("rst_avail", 64'(bus.dsp_num_avail), 64'd16);
    chk("rst_ret_v", 64'(bus.ret_v), 64'd0);
    for (int i = 0; i < 3; i++) chk("rst_dsp_ptr", 64'(bus.dsp_ptr[i]), 64'(i));
    for (int i = 0; i < 2; i++) begin
      chk("rst_ret_ptr", 64'(bus.ret_ptr[i]), 64'(i));
      chk("rst_ret_dat", 64'(bus.ret_dat[i]), 64'd0);
      chk("rst_ret_res", 64'(bus.ret_res[i]), 64'd0);
      chk("rst_ret_exc", 64'(bus.ret_exc[i]), 64'd0);
    end
    rst = 1'b0;

    for (int r = 0; r < 16; r++) begin
      clear_inputs();
      set_disp(vt[r].dsp_p);
      if (vt[r].wbv) set_wb(0, vt[r].wbs, vt[r].wbe);
      bus.ret_p = vt[r].ret_p;
      cycle();
      chk("tbl_occ", 64'(bus.occ), 64'(vt[r].occ));
      chk("tbl_avail", 64'(bus.dsp_num_avail), 64'(N - vt[r].occ));
      chk("tbl_ret_v", 64'(bus.ret_v), 64'(vt[r].rv));
      chk("tbl_dsp_ptr0", 64'(bus.dsp_ptr[0]), 64'(vt[r].dptr0));
      chk("tbl_ret_exc0", 64'(bus.ret_exc[0]), 64'(vt[r].exc0));
    end

    // Flush overrides same-cycle dispatch, write-back and retire.
    clear_inputs();
    bus.flush = 1'b1;
    set_disp(3'b111);
    set_wb(0, 5, 1'b0);
    bus.ret_p = 2'b11;
    cycle();
    chk("flush_occ", 64'(bus.occ), 64'd0);
    chk("flush_ret_v", 64'(bus.ret_v), 64'd0);
    chk("flush_dsp_ptr0", 64'(bus.dsp_ptr[0]), 64'd0);

    // Build 10 entries at rptr=4 (slots 4..13), slots 4..6 done.
    clear_inputs(); set_disp(3'b111); cycle();
    clear_inputs(); set_disp(3'b111); set_wb(0, 0, 1'b0); set_wb(1, 1, 1'b0); set_wb(2, 2, 1'b0); cycle();
    clear_inputs(); set_disp(3'b111); set_wb(0, 3, 1'b0); set_wb(1, 4, 1'b0); set_wb(2, 5, 1'b0);
    bus.ret_p = 2'b11; cycle();
    clear_inputs(); set_disp(3'b111); set_wb(0, 6, 1'b0); bus.ret_p = 2'b11; cycle();
    clear_inputs(); set_disp(3'b011); cycle();
    chk("presq_occ", 64'(bus.occ), 64'd10);
    chk("presq_rptr", 64'(bus.ret_ptr[0]), 64'd4);

    clear_inputs();
    bus.squash = 1'b1;
    bus.squash_ptr = 4'd7;
    set_disp(3'b111);
    set_wb(0, 9, 1'b0);
    set_wb(1, 7, 1'b0);
    cycle();
    chk("sq_occ", 64'(bus.occ), 64'd4);
    chk("sq_avail", 64'(bus.dsp_num_avail), 64'd12);
    chk("sq_dsp_ptr0", 64'(bus.dsp_ptr[0]), 64'd8);
    chk("sq_ret_v", 64'(bus.ret_v), 64'd3);

    clear_inputs(); set_disp(3'b001); bus.ret_p = 2'b11; cycle();
    clear_inputs(); bus.ret_p = 2'b11; cycle();
    chk("sq_drain_occ", 64'(bus.occ), 64'd1);
    chk("sq_drain_ret_v", 64'(bus.ret_v), 64'd0);
    clear_inputs(); bus.squash = 1'b1; bus.squash_ptr = 4'd12; cycle();
    chk("sq_unocc_occ", 64'(bus.occ), 64'd1);

    // Fill to full, then stream 2 in / 2 out across several wraps.
    clear_inputs(); bus.flush = 1'b1; cycle();
    seq = 0;
    next_ret = 0;
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      bus.dsp_p = (c < 5) ? 3'b111 : 3'b001;
      for (int i = 0; i < 3; i++) bus.dsp_dat[i] = 32'(seq + i);
      seq += (c < 5) ? 3 : 1;
      cycle();
    end
    chk("full_occ", 64'(bus.occ), 64'd16);
    chk("full_avail", 64'(bus.dsp_num_avail), 64'd0);
    for (int c = 0; c < 60; c++) begin
      logic acc;
      clear_inputs();
      acc = (N - mq.size()) >= 2;
      bus.dsp_p = 3'b011;
      bus.dsp_dat[0] = 32'(seq);
      bus.dsp_dat[1] = 32'(seq + 1);
      for (int p = 0; p < 4; p++) set_wb(p, (m_rd + p) & 15, 1'b0);
      bus.ret_p = 2'b11;
      if (bus.ret_v[0]) chk("stream_order0", 64'(bus.ret_dat[0]), 64'(next_ret));
      if (bus.ret_v[1]) chk("stream_order1", 64'(bus.ret_dat[1]), 64'(next_ret + 1));
      next_ret += (bus.ret_v[1] ? 2 : (bus.ret_v[0] ? 1 : 0));
      if (acc) seq += 2;
      cycle();
      chk("stream_occ_sum", 64'(bus.occ) + 64'(bus.dsp_num_avail), 64'd16);
    end
    chk("stream_progress", 64'(next_ret > 100), 64'd1);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      clear_inputs();
      set_disp(3'($urandom_range(0, 7)));
      for (int p = 0; p < 4; p++)
        if ($urandom_range(0, 2) != 0) set_wb(p, (m_rd + $urandom_range(0, 15)) & 15, $urandom_range(0, 7) == 0);
      bus.ret_p = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) begin
        bus.squash = 1'b1;
        bus.squash_ptr = 4'($urandom_range(0, 15));
      end
      bus.flush = ($urandom_range(0, 79) == 0);
      cycle();
    end

    // Asynchronous reset between clock edges.
    clear_inputs(); set_disp(3'b111); cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_occ", 64'(bus.occ), 64'd0);
    chk("arst_ret_v", 64'(bus.ret_v), 64'd0);
    chk("arst_dsp_ptr0", 64'(bus.dsp_ptr[0]), 64'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/re_order_buffer_mr.md
# re_order_buffer_mr

Parametrised successor ROB sitting between dispatch and the architectural commit stage. It accepts up to DISP instructions per cycle in program order and takes results from WB execution-unit write-back ports out of order. It retires up to RET completed entries per cycle in order, with their results and exception flags. Unlike the single-tail ROB, it stores results, stops retirement at faulting entries, and supports full flush and partial squash of younger entries.

## Interface
- ROB_LEN, 16, entries; must be a power of 2 (elaboration error otherwise); PW = $clog2(ROB_LEN)
- DISP, 3, dispatch (head) ports
- RET, 2, retire (tail) ports
- WB, 4, write-back side ports
- DAT_W, 32, dispatch payload width
- RES_W, 32, result width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- dsp_p  in  DISP  push mask; must be contiguous from bit 0
- dsp_dat  in  DISP×DAT_W  payload per push port
- dsp_ptr  out  DISP×PW  slot index port i receives (wptr+i mod ROB_LEN)
- dsp_num_avail  out  PW+1  free slots, 0..ROB_LEN
- occ  out  PW+1  occupied slots, 0..ROB_LEN
- wb_v  in  WB  write-back valid
- wb_ptr  in  WB×PW  target slot
- wb_res  in  WB×RES_W  result
- wb_exc  in  WB  exception flag
- ret_v  out  RET  tail i retirable
- ret_dat / ret_res / ret_exc / ret_ptr  out  RET×(DAT_W / RES_W / 1 / PW)  entry at rptr+i
- ret_p  in  RET  pop mask; contiguous from bit 0
- flush  in  1  discard all entries
- squash  in  1  discard all entries younger than squash_ptr
- squash_ptr  in  PW  youngest surviving slot

## Operation
- State: per slot {dat, res, exc, done}; rptr, wptr of PW+1 bits (wrap bit); occ = wptr−rptr, dsp_num_avail = ROB_LEN−occ.
- Dispatch: n = popcount(dsp_p). If n ≤ dsp_num_avail, write n entries at wptr.., clear done/exc, and advance wptr by n. Otherwise, ignore the whole group (all-or-nothing). Non-contiguous dsp_p: only the leading run of ones counts.
- Write-back: a slot is occupied iff (slot−rptr[PW-1:0]) mod ROB_LEN < occ. An occupied slot gets res, exc, done=1. An unoccupied slot is ignored. Same slot on two ports in one cycle: the highest port index wins. A re-write to a done slot overwrites it.
- ret_v[i] = slot rptr+i occupied & done & ret_v[i−1] & !exc(slot rptr+i−1); ret_v[0] has no predecessor term. A faulting entry is presented (ret_exc=1), and nothing behind it is retirable.
- Retire: k = length of the leading ones of (ret_p & ret_v). Advance rptr by k and clear done of the popped slots. ret_p bits without ret_v are ignored.
- Flush: rptr=wptr=0, all done=0. It overrides dispatch, write-back, retire and squash in the same cycle.
- Squash: only if squash_ptr is occupied (otherwise ignored). wptr := unwrapped index of squash_ptr + 1. Dispatch in the same cycle is ignored. Retire in the same cycle still applies, including popping the squash_ptr slot itself. Write-back to discarded slots in the same cycle is ignored.
- Order of evaluation within a cycle: flush > squash > {retire, write-back, dispatch}. Occupancy checks and dsp_num_avail use pre-edge state (no bypass of same-cycle retire into free count).

## Timing
- Reset (async assert, all state): rptr=wptr=0, all done/exc=0. Outputs: occ=0, dsp_num_avail=ROB_LEN, dsp_ptr[i]=i, ret_v=0, ret_dat/res/exc=0, ret_ptr[i]=i.
- All outputs are combinational from registered state; no input-to-output combinational path.
- Dispatch at edge N: the slot is write-back-able from cycle N+1.
- Write-back at edge N: the entry shows ret_v from cycle N+1, giving a minimum dispatch→retire of 2 cycles.
- Retire at edge N frees slots, counted in dsp_num_avail from cycle N+1.
- Wrap-around: pointer wrap bit distinguishes full (occ=ROB_LEN) from empty (occ=0).
- Reset mid-operation discards all entries; there is no recovery of in-flight state.

## Test plan
- Reset, then dispatch 3/cycle for 6 cycles with ROB_LEN=16 → 5 groups accepted (occ=15). The 6th group is rejected because 3>1, so occ stays 15 and dsp_ptr stays {15,0,1}.
- Write-back slots 2,1,0 in reverse order over 3 cycles → ret_v stays 00 until slot 0 is done. Then ret_v=11 with ret_ptr={0,1}; ret_p=11 pops both, and occ drops by 2 next cycle.
- Write-back slot 0 with exc=1 and slot 1 done → ret_v=01, ret_exc[0]=1. Popping it makes slot 1 retirable the next cycle.
- Fill to 16 and drain with 2/cycle retire while dispatching 2/cycle across ≥3 wraps → result order matches dispatch order, and occ/dsp_num_avail always sum to 16.
- With 10 entries at rptr=4, assert squash_ptr=7 → occ=4 and wptr=8. A same-cycle write-back to slot 9 is ignored, and the next dispatch gets dsp_ptr[0]=8.
- Assert flush together with dispatch, write-back and ret_p → next cycle occ=0, ret_v=0, dsp_ptr[0]=0. An async rst pulse mid-traffic gives the same result immediately.
